// File: rtl/pc_gen_pkg.sv
// Shared configuration for the fetch PC generator: default widths, reset vector,
// IF stall-bit position and the fetch-source selector type.
package pc_gen_pkg;

   localparam int unsigned ADDR_W_DEF     = 32;
   localparam int unsigned RESET_VEC_DEF  = 0;
   localparam int unsigned INST_BYTES_DEF = 4;
   localparam int unsigned IF_STALL_BIT   = 0;

   typedef enum logic [1:0] {
      SRC_NPC   = 2'd0,
      SRC_PEND  = 2'd1,
      SRC_REDIR = 2'd2
   } pc_src_e;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } pc_state_e;

   // A live redirect always beats a held one; a held one beats sequential flow.
   function automatic pc_src_e fetch_src(input logic redirect, input logic pend_v);
      if (redirect)    return SRC_REDIR;
      else if (pend_v) return SRC_PEND;
      else             return SRC_NPC;
   endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer for pc_gen (instantiated only with PC_BTB_EN).
// Combinational lookup; updates land on the clock edge and are not forwarded.
module pc_btb #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned INST_BYTES = 4,
   parameter int unsigned DEPTH      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [ADDR_W-1:0] target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken
);

   localparam int unsigned OFS_W = $clog2(INST_BYTES);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFS_W;

   logic [DEPTH-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q    [DEPTH];
   logic [ADDR_W-1:0] target_q [DEPTH];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_tag_hit;
   logic             addr_unused;

   assign lk_idx = lookup_addr[IDX_W+OFS_W-1:OFS_W];
   assign lk_tag = lookup_addr[ADDR_W-1:IDX_W+OFS_W];
   assign up_idx = upd_pc[IDX_W+OFS_W-1:OFS_W];
   assign up_tag = upd_pc[ADDR_W-1:IDX_W+OFS_W];

   assign addr_unused = ^{lookup_addr, upd_pc};

   assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign target     = target_q[lk_idx];
   assign up_tag_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (upd_en) begin
         if (upd_taken)       valid_q[up_idx] <= 1'b1;
         else if (up_tag_hit) valid_q[up_idx] <= 1'b0;
      end
   end

   // Tag/target need no reset: they are only observed through valid_q.
   always_ff @(posedge clk) begin
      if (upd_en && upd_taken) begin
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= upd_target;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: sequential fetch, held redirects under stall,
// optional BTB next-address prediction enabled by defining PC_BTB_EN.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned              ADDR_W     = ADDR_W_DEF,
   parameter logic        [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF),
   parameter int unsigned              INST_BYTES = INST_BYTES_DEF,
   parameter int unsigned              STALL_W    = 6,
   parameter int unsigned              BTB_DEPTH  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic [ADDR_W-1:0]  pc_o,
   output logic               pc_valid_o,
   output logic               redirect_o,
   output logic               pred_taken_o,
   input  logic               upd_en,
   input  logic [ADDR_W-1:0]  upd_pc,
   input  logic [ADDR_W-1:0]  upd_target,
   input  logic               upd_taken
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

   pc_state_e         state_q, state_d;
   pc_src_e           src;
   logic [ADDR_W-1:0] npc, npc_d;
   logic              pend_v;
   logic [ADDR_W-1:0] pend_addr;
   logic [ADDR_W-1:0] sel_raw, sel;
   logic              advance;
   logic              redir_d;
   logic              btb_hit;
   logic [ADDR_W-1:0] btb_target;
   logic              stall_unused;

   assign advance      = !stall[IF_STALL_BIT];
   assign stall_unused = ^stall;

   always_comb begin
      src     = fetch_src(redirect, pend_v);
      sel_raw = npc;
      case (src)
         SRC_REDIR: sel_raw = redirect_addr;
         SRC_PEND:  sel_raw = pend_addr;
         default:   sel_raw = npc;
      endcase
      sel   = sel_raw & ALIGN_MASK;
      npc_d = btb_hit ? btb_target : sel + ADDR_W'(INST_BYTES);
   end

   // The boot state marks the first emitted PC after reset as a redirect.
   always_comb begin
      state_d = state_q;
      redir_d = redirect | pend_v | (state_q == ST_BOOT);
      if (advance) state_d = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_BOOT;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_o         <= RESET_VEC;
         pc_valid_o   <= 1'b0;
         redirect_o   <= 1'b0;
         pred_taken_o <= 1'b0;
         npc          <= RESET_VEC;
         pend_v       <= 1'b0;
         pend_addr    <= '0;
      end else if (advance) begin
         pc_o         <= sel;
         pc_valid_o   <= 1'b1;
         redirect_o   <= redir_d;
         pred_taken_o <= btb_hit;
         npc          <= npc_d;
         pend_v       <= 1'b0;
      end else if (redirect) begin
         pend_v    <= 1'b1;
         pend_addr <= redirect_addr;
      end
   end

`ifdef PC_BTB_EN
   pc_btb #(
      .ADDR_W     (ADDR_W),
      .INST_BYTES (INST_BYTES),
      .DEPTH      (BTB_DEPTH)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .lookup_addr (sel),
      .hit         (btb_hit),
      .target      (btb_target),
      .upd_en      (upd_en),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken)
   );
`else
   logic        upd_unused;
   logic [31:0] cfg_unused;

   assign btb_hit    = 1'b0;
   assign btb_target = '0;
   assign upd_unused = ^{upd_en, upd_pc, upd_target, upd_taken};
   assign cfg_unused = BTB_DEPTH;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance for fetch/redirect/stall/BTB
// behaviour and an 8-bit instance for address wrap.
module tb_pc_gen;

   typedef struct packed {
      logic [31:0] pc;
      logic        r;
      logic        p;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall, stall8;
   logic        redirect, redirect8;
   logic [31:0] raddr;
   logic [7:0]  raddr8;
   logic        upd_en, upd_taken;
   logic [31:0] upd_pc, upd_target;

   logic [31:0] pc_o;
   logic        pc_valid_o, redirect_o, pred_taken_o;
   logic [7:0]  pc8_o;
   logic        pc8_valid_o, redirect8_o, pred8_taken_o;

   exp_t q[$];
   exp_t q8[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   pc_gen #(
      .ADDR_W     (32),
      .RESET_VEC  (32'h0),
      .INST_BYTES (4),
      .STALL_W    (6),
      .BTB_DEPTH  (8)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_addr (raddr),
      .pc_o          (pc_o),
      .pc_valid_o    (pc_valid_o),
      .redirect_o    (redirect_o),
      .pred_taken_o  (pred_taken_o),
      .upd_en        (upd_en),
      .upd_pc        (upd_pc),
      .upd_target    (upd_target),
      .upd_taken     (upd_taken)
   );

   pc_gen #(
      .ADDR_W     (8),
      .RESET_VEC  (8'h0),
      .INST_BYTES (4),
      .STALL_W    (6),
      .BTB_DEPTH  (8)
   ) u_dut8 (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall8),
      .redirect      (redirect8),
      .redirect_addr (raddr8),
      .pc_o          (pc8_o),
      .pc_valid_o    (pc8_valid_o),
      .redirect_o    (redirect8_o),
      .pred_taken_o  (pred8_taken_o),
      .upd_en        (1'b0),
      .upd_pc        (8'h0),
      .upd_target    (8'h0),
      .upd_taken     (1'b0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Monitor: an edge with rst=1 and stall[0]=0 presents a new PC.
   initial begin
      logic adv, adv8;
      exp_t e;
      forever begin
         @(posedge clk);
         adv  = (rst === 1'b1) && (stall[0] === 1'b0);
         adv8 = (rst === 1'b1) && (stall8[0] === 1'b0);
         #1;
         if (adv) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_emit: got pc %h, want none", pc_o);
            end else begin
               e = q.pop_front();
               chk("pc_o", pc_o, e.pc);
               chk("redirect_o", {31'b0, redirect_o}, {31'b0, e.r});
               chk("pred_taken_o", {31'b0, pred_taken_o}, {31'b0, e.p});
               chk("pc_valid_o", {31'b0, pc_valid_o}, 32'd1);
            end
         end
         if (adv8) begin
            if (q8.size() == 0) begin
               checks++;
               $display("FAIL unexpected_emit8: got pc %h, want none", pc8_o);
            end else begin
               e = q8.pop_front();
               chk("pc8_o", {24'b0, pc8_o}, {24'b0, e.pc[7:0]});
               chk("redirect8_o", {31'b0, redirect8_o}, {31'b0, e.r});
               chk("pred8_taken_o", {31'b0, pred8_taken_o}, 32'd0);
            end
         end
      end
   end

   task automatic step(input logic s, input logic r, input logic [31:0] a,
                       input logic [31:0] epc, input logic er, input logic ep);
      @(negedge clk);
      stall[0] = s;
      redirect = r;
      raddr    = a;
      if (rst && !s) q.push_back(exp_t'{epc, er, ep});
   endtask

   task automatic step8(input logic s, input logic r, input logic [7:0] a,
                        input logic [7:0] epc, input logic er);
      @(negedge clk);
      stall8[0] = s;
      redirect8 = r;
      raddr8    = a;
      if (rst && !s) q8.push_back(exp_t'{{24'b0, epc}, er, 1'b0});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pc"}, pc_o, 32'h0);
      chk({tag, "_valid"}, {31'b0, pc_valid_o}, 32'd0);
      chk({tag, "_redir"}, {31'b0, redirect_o}, 32'd0);
      chk({tag, "_pred"}, {31'b0, pred_taken_o}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; stall = 6'h01; stall8 = 6'h01;
      redirect = 1'b0; raddr = '0; redirect8 = 1'b0; raddr8 = '0;
      upd_en = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;

      // Reset held three cycles, then released while still stalled
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);
      chk("stall_after_reset_valid", {31'b0, pc_valid_o}, 32'd0);

      // Sequential fetch; first PC after reset is flagged as a redirect
      step(0, 0, 32'h0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 32'h4, 0, 0);
      step(0, 0, 32'h0, 32'h8, 0, 0);
      step(0, 0, 32'h0, 32'hC, 0, 0);
      // Unstalled redirect: target next cycle, then sequential
      step(0, 1, 32'h100, 32'h100, 1, 0);
      step(0, 0, 32'h0,   32'h104, 0, 0);
      step(0, 0, 32'h0,   32'h108, 0, 0);
      // Two redirects under stall: newest wins, outputs hold
      step(1, 1, 32'h200, 32'h0, 0, 0);
      step(1, 1, 32'h300, 32'h0, 0, 0);
      step(1, 0, 32'h0,   32'h0, 0, 0);
      chk("stall_hold_pc", pc_o, 32'h108);
      chk("stall_hold_redir", {31'b0, redirect_o}, 32'd0);
      step(0, 0, 32'h0, 32'h300, 1, 0);
      step(0, 0, 32'h0, 32'h304, 0, 0);
      // Redirect to the address that would come anyway
      step(0, 1, 32'h308, 32'h308, 1, 0);
      step(0, 0, 32'h0,   32'h30C, 0, 0);
      // Misaligned target is aligned down
      step(0, 1, 32'h103, 32'h100, 1, 0);
      step(0, 0, 32'h0,   32'h104, 0, 0);
      // Full-width wrap
      step(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
      step(0, 0, 32'h0, 32'h0, 0, 0);
      step(0, 0, 32'h0, 32'h4, 0, 0);
      // Live redirect on release beats the held one
      step(1, 1, 32'h500, 32'h0, 0, 0);
      step(0, 1, 32'h600, 32'h600, 1, 0);
      step(0, 0, 32'h0,   32'h604, 0, 0);

      // BTB install 0x40 -> 0x80, then invalidate
      step(0, 0, 32'h0, 32'h608, 0, 0);
      upd_en = 1'b1; upd_pc = 32'h40; upd_target = 32'h80; upd_taken = 1'b1;
`ifdef PC_BTB_EN
      step(0, 1, 32'h40, 32'h40, 1, 1);
      upd_en = 1'b0;
      step(0, 0, 32'h0, 32'h80, 0, 0);
      step(0, 0, 32'h0, 32'h84, 0, 0);
      step(0, 0, 32'h0, 32'h88, 0, 0);
`else
      step(0, 1, 32'h40, 32'h40, 1, 0);
      upd_en = 1'b0;
      step(0, 0, 32'h0, 32'h44, 0, 0);
      step(0, 0, 32'h0, 32'h48, 0, 0);
      step(0, 0, 32'h0, 32'h4C, 0, 0);
`endif
      upd_en = 1'b1; upd_taken = 1'b0;
      step(0, 1, 32'h40, 32'h40, 1, 0);
      upd_en = 1'b0;
      step(0, 0, 32'h0, 32'h44, 0, 0);

      // Reset mid-stall with a held redirect: held target is dropped
      step(1, 1, 32'h700, 32'h0, 0, 0);
      step(1, 0, 32'h0,   32'h0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midstall_reset");
      rst = 1'b1; stall[0] = 1'b0; redirect = 1'b0;
      q.push_back(exp_t'{32'h0, 1'b1, 1'b0});
      step(0, 0, 32'h0, 32'h4, 0, 0);
      step(1, 0, 32'h0, 32'h0, 0, 0);

      // 8-bit instance: wrap and alignment
      step8(0, 0, 8'h00, 8'h00, 1);
      step8(0, 1, 8'hFC, 8'hFC, 1);
      step8(0, 0, 8'h00, 8'h00, 0);
      step8(0, 0, 8'h00, 8'h04, 0);
      step8(0, 1, 8'hFF, 8'hFC, 1);
      step8(0, 0, 8'h00, 8'h00, 0);
      step8(1, 0, 8'h00, 8'h00, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size() + q8.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
